lbm_stream_engine: RTL and testbench

- Parametrised D2Q9 pull-streaming engine for the LBM datapath.
- Sweeps an NX x NY grid of packed distribution words from a source memory and writes the streamed words to a destination memory.
- Supports periodic or top/bottom bounce-back wall handling and counts completed time steps.
- Sits between the collision stage's output memory and the next time step's input memory.

---
 rtl/lbm_stream_engine_if.sv | 46 ++++
 rtl/lbm_stream_engine.sv | 223 ++++++++++++++++++++++
 tb/tb_lbm_stream_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lbm_stream_engine_if.sv
// lbm_stream_engine_if: start/status, source-read and destination-write
// bundle for lbm_stream_engine. The engine uses the master modport and the
// memory/controller side uses the slave modport.
// Optional macro LBM_STREAM_PERF_EN adds the stall_cycles status word.
interface lbm_stream_engine_if #(
  parameter int DATA_WIDTH_F     = 288,
  parameter int ADDRESS_WIDTH    = 8,
  parameter int TIME_COUNT_WIDTH = 3
);
  logic                        start;
  logic                        busy;
  logic                        done;
  logic [TIME_COUNT_WIDTH-1:0] step_count;
  logic                        src_rd_en;
  logic [ADDRESS_WIDTH-1:0]    src_rd_addr;
  logic [DATA_WIDTH_F-1:0]     src_rd_data;
  logic                        dst_wr_en;
  logic [ADDRESS_WIDTH-1:0]    dst_wr_addr;
  logic [DATA_WIDTH_F-1:0]     dst_wr_data;
  logic                        dst_wr_ready;
`ifdef LBM_STREAM_PERF_EN
  logic [31:0]                 stall_cycles;

  modport master (
    input  start, src_rd_data, dst_wr_ready,
    output busy, done, step_count, src_rd_en, src_rd_addr,
    output dst_wr_en, dst_wr_addr, dst_wr_data, stall_cycles
  );
  modport slave (
    output start, src_rd_data, dst_wr_ready,
    input  busy, done, step_count, src_rd_en, src_rd_addr,
    input  dst_wr_en, dst_wr_addr, dst_wr_data, stall_cycles
  );
`else
  modport master (
    input  start, src_rd_data, dst_wr_ready,
    output busy, done, step_count, src_rd_en, src_rd_addr,
    output dst_wr_en, dst_wr_addr, dst_wr_data
  );
  modport slave (
    output start, src_rd_data, dst_wr_ready,
    input  busy, done, step_count, src_rd_en, src_rd_addr,
    input  dst_wr_en, dst_wr_addr, dst_wr_data
  );
`endif
endinterface

// File: rtl/lbm_stream_engine.sv
// lbm_stream_engine: D2Q9 pull-streaming engine. For every node of an
// NX x NY grid it reads the nine source words its directions pull from,
// keeps one component of each, and writes the assembled word to the
// destination memory. Node period is 9 reads + 1 drain + 1 write cycle.
// Optional macro LBM_STREAM_PERF_EN adds a saturating write-stall counter.
module lbm_stream_engine #(
  parameter int NX               = 16,
  parameter int NY               = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int DATA_WIDTH_F     = 9*DATA_WIDTH,
  parameter int ADDRESS_WIDTH    = $clog2(NX*NY),
  parameter int WALL_MODE        = 0,
  parameter int MAX_TIME         = 8,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME)
)(
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  lbm_stream_engine_if.master  bus
);

  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(NX-1);
  localparam logic [YW-1:0] Y_MAX = YW'(NY-1);
  localparam logic [3:0]    DIR_LAST = 4'd8;
  localparam logic [TIME_COUNT_WIDTH-1:0] STEP_MAX = TIME_COUNT_WIDTH'(MAX_TIME-1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE} state_t;

  // Lattice velocity x component of direction d.
  function automatic logic signed [1:0] f_cx(input logic [3:0] d);
    case (d)
      4'd1, 4'd5, 4'd8: f_cx = 2'sd1;
      4'd3, 4'd6, 4'd7: f_cx = -2'sd1;
      default:          f_cx = 2'sd0;
    endcase
  endfunction

  // Lattice velocity y component of direction d.
  function automatic logic signed [1:0] f_cy(input logic [3:0] d);
    case (d)
      4'd2, 4'd5, 4'd6: f_cy = 2'sd1;
      4'd4, 4'd7, 4'd8: f_cy = -2'sd1;
      default:          f_cy = 2'sd0;
    endcase
  endfunction

  // Direction pointing the opposite way, used for wall bounce-back.
  function automatic logic [3:0] f_opp(input logic [3:0] d);
    case (d)
      4'd1:    f_opp = 4'd3;
      4'd2:    f_opp = 4'd4;
      4'd3:    f_opp = 4'd1;
      4'd4:    f_opp = 4'd2;
      4'd5:    f_opp = 4'd7;
      4'd6:    f_opp = 4'd8;
      4'd7:    f_opp = 4'd5;
      4'd8:    f_opp = 4'd6;
      default: f_opp = 4'd0;
    endcase
  endfunction

  // Saturating increment for the stall counter.
  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    f_sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t                      r_state;
  state_t                      w_next;
  logic [XW-1:0]               r_x;
  logic [YW-1:0]               r_y;
  logic [3:0]                  r_dir;
  logic                        r_done;
  logic [TIME_COUNT_WIDTH-1:0] r_step;

  logic                        r_vld_p1;
  logic [3:0]                  r_lane_p1;
  logic [3:0]                  r_sel_p1;
  logic signed [DATA_WIDTH-1:0] r_asm_p2 [0:8];

  logic signed [1:0]           w_cx;
  logic signed [1:0]           w_cy;
  logic [XW-1:0]               w_sx;
  logic [YW-1:0]               w_sy;
  logic                        w_bounce;
  logic [3:0]                  w_sel;
  logic [ADDRESS_WIDTH-1:0]    w_rd_addr;
  logic [ADDRESS_WIDTH-1:0]    w_own_addr;
  logic                        w_last_node;
  logic                        w_accept;
  logic                        w_start_acc;
  logic signed [DATA_WIDTH-1:0] w_src_comp [0:8];
  logic [DATA_WIDTH_F-1:0]     w_asm_word;

  assign w_own_addr  = ADDRESS_WIDTH'(int'(r_y) * NX + int'(r_x));
  assign w_last_node = (r_x == X_MAX) && (r_y == Y_MAX);
  assign w_accept    = (r_state == S_WRITE) && bus.dst_wr_ready;
  // A start in the done cycle is ignored; it must still be high one cycle later.
  assign w_start_acc = (r_state == S_IDLE) && bus.start && !r_done;

  // Source coordinate for the current direction: wrap by compare/select, or bounce at a wall.
  always_comb begin
    w_cx     = f_cx(r_dir);
    w_cy     = f_cy(r_dir);
    w_sx     = r_x;
    w_sy     = r_y;
    w_bounce = 1'b0;
    if (w_cx == 2'sd1)       w_sx = (r_x == '0)    ? X_MAX : r_x - 1'b1;
    else if (w_cx == -2'sd1) w_sx = (r_x == X_MAX) ? '0    : r_x + 1'b1;
    if (w_cy == 2'sd1) begin
      if (r_y != '0)          w_sy = r_y - 1'b1;
      else if (WALL_MODE == 1) w_bounce = 1'b1;
      else                    w_sy = Y_MAX;
    end else if (w_cy == -2'sd1) begin
      if (r_y != Y_MAX)       w_sy = r_y + 1'b1;
      else if (WALL_MODE == 1) w_bounce = 1'b1;
      else                    w_sy = '0;
    end
    if (w_bounce) begin
      w_sx = r_x;
      w_sy = r_y;
    end
    w_sel     = w_bounce ? f_opp(r_dir) : r_dir;
    w_rd_addr = ADDRESS_WIDTH'(int'(w_sy) * NX + int'(w_sx));
  end

  // Split the returned source word into its nine components.
  always_comb begin
    for (int i = 0; i < 9; i++) w_src_comp[i] = bus.src_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Pack the assembly lanes into the destination word.
  always_comb begin
    w_asm_word = '0;
    for (int i = 0; i < 9; i++) w_asm_word[i*DATA_WIDTH +: DATA_WIDTH] = r_asm_p2[i];
  end

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_next = S_READ;
      S_READ:  if (r_dir == DIR_LAST) w_next = S_DRAIN;
      S_DRAIN: w_next = S_WRITE;
      S_WRITE: if (bus.dst_wr_ready) w_next = w_last_node ? S_IDLE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; addresses and data are zero outside their phase.
  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.src_rd_en   = (r_state == S_READ);
    bus.src_rd_addr = (r_state == S_READ)  ? w_rd_addr  : '0;
    bus.dst_wr_en   = (r_state == S_WRITE);
    bus.dst_wr_addr = (r_state == S_WRITE) ? w_own_addr : '0;
    bus.dst_wr_data = (r_state == S_WRITE) ? w_asm_word : '0;
    bus.done        = r_done;
    bus.step_count  = r_step;
  end

  // Node/direction counters, step counter, done pulse and the read-return tag.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_x       <= '0;
      r_y       <= '0;
      r_dir     <= '0;
      r_done    <= 1'b0;
      r_step    <= '0;
      r_vld_p1  <= 1'b0;
      r_lane_p1 <= '0;
      r_sel_p1  <= '0;
    end else begin
      // p0 -> p1: tag the read issued this cycle with its lane and component
      r_vld_p1  <= (r_state == S_READ);
      r_lane_p1 <= r_dir;
      r_sel_p1  <= w_sel;
      r_done    <= w_accept && w_last_node;
      if (r_state == S_READ) r_dir <= (r_dir == DIR_LAST) ? 4'd0 : r_dir + 4'd1;
      if (w_accept) begin
        if (w_last_node) begin
          r_x    <= '0;
          r_y    <= '0;
          r_step <= (r_step == STEP_MAX) ? '0 : r_step + 1'b1;
        end else if (r_x == X_MAX) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  // p1 -> p2: capture the selected component of the returned word into its lane.
  always_ff @(posedge CLOCK_50) begin
    if (r_vld_p1) begin
      for (int i = 0; i < 9; i++) begin
        if (r_lane_p1 == 4'(i)) r_asm_p2[i] <= w_src_comp[r_sel_p1];
      end
    end
  end

`ifdef LBM_STREAM_PERF_EN
  logic [31:0] r_stall;

  // Count write cycles the destination refuses; restart on each accepted start.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                                             r_stall <= '0;
    else if (w_start_acc)                                  r_stall <= '0;
    else if ((r_state == S_WRITE) && !bus.dst_wr_ready)    r_stall <= f_sat_inc(r_stall);
  end

  assign bus.stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_lbm_stream_engine.sv
// tb_lbm_stream_engine: runs a periodic and a bounce-back engine side by side
// on a 4x4 grid, checks every destination write against a streaming model,
// and checks timing, backpressure, step counting and reset behaviour.
module tb_lbm_stream_engine;
  localparam int NX  = 4;
  localparam int NY  = 4;
  localparam int NN  = NX*NY;
  localparam int DW  = 32;
  localparam int DWF = 9*DW;
  localparam int AW  = 4;
  localparam int TCW = 3;

  localparam int CX  [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CY  [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  localparam int OPP [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lbm_stream_engine_if #(.DATA_WIDTH_F(DWF), .ADDRESS_WIDTH(AW), .TIME_COUNT_WIDTH(TCW)) bp ();
  lbm_stream_engine_if #(.DATA_WIDTH_F(DWF), .ADDRESS_WIDTH(AW), .TIME_COUNT_WIDTH(TCW)) bw ();

  lbm_stream_engine #(.NX(NX), .NY(NY), .DATA_WIDTH(DW), .WALL_MODE(0), .MAX_TIME(8))
    u_per (.CLOCK_50(clk), .RESET(rst), .bus(bp.master));
  lbm_stream_engine #(.NX(NX), .NY(NY), .DATA_WIDTH(DW), .WALL_MODE(1), .MAX_TIME(8))
    u_wall (.CLOCK_50(clk), .RESET(rst), .bus(bw.master));

  assign bp.start = start;
  assign bw.start = start;
  assign bp.dst_wr_ready = ready;
  assign bw.dst_wr_ready = ready;

  // Source memory: node a holds f_i = a*16 + i, returned one cycle after the read.
  logic [DWF-1:0] src_mem [NN];
  initial begin
    for (int a = 0; a < NN; a++)
      for (int i = 0; i < 9; i++) src_mem[a][i*DW +: DW] = DW'(a*16 + i);
  end

  always @(posedge clk) begin
    if (bp.src_rd_en) bp.src_rd_data <= src_mem[bp.src_rd_addr];
    if (bw.src_rd_en) bw.src_rd_data <= src_mem[bw.src_rd_addr];
  end

  task automatic check(input string name, input logic [DWF-1:0] got, input logic [DWF-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Streamed word of a node, from the pull rule with modular wrap or wall bounce.
  function automatic logic [DWF-1:0] model_word(input int mode, input int node);
    logic [DWF-1:0] w;
    int x, y, sx, sy, snode, comp;
    w = '0;
    x = node % NX;
    y = node / NX;
    for (int i = 0; i < 9; i++) begin
      sx = (x - CX[i] + NX) % NX;
      sy = y - CY[i];
      comp = i;
      if (sy < 0 || sy >= NY) begin
        if (mode == 0) begin
          sy = (sy + NY) % NY;
          snode = sy*NX + sx;
        end else begin
          snode = node;
          comp = OPP[i];
        end
      end else begin
        snode = sy*NX + sx;
      end
      w[i*DW +: DW] = DW'(snode*16 + comp);
    end
    return w;
  endfunction

  // Scoreboard: writes must visit nodes in order with the model's word.
  int             exp_node [2];
  logic [DWF-1:0] got_word [2][NN];

  task automatic mon(input int k, input logic en, input logic [AW-1:0] addr,
                     input logic [DWF-1:0] data, input logic rd);
    if (en) begin
      check($sformatf("wr_addr[%0d]", k), DWF'(addr), DWF'(exp_node[k]));
      check($sformatf("wr_data[%0d] node %0d", k, exp_node[k]), data, model_word(k, exp_node[k]));
      check($sformatf("rd_during_wr[%0d]", k), DWF'(rd), '0);
      got_word[k][exp_node[k]] = data;
      if (ready) exp_node[k] = (exp_node[k] + 1) % NN;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst) begin
      exp_node[0] = 0;
      exp_node[1] = 0;
    end else begin
      mon(0, bp.dst_wr_en, bp.dst_wr_addr, bp.dst_wr_data, bp.src_rd_en);
      mon(1, bw.dst_wr_en, bw.dst_wr_addr, bw.dst_wr_data, bw.src_rd_en);
    end
  end

  task automatic check_zero(input string tag);
    check({tag, " ctl_per"},  DWF'({bp.busy, bp.done, bp.step_count, bp.src_rd_en, bp.src_rd_addr,
                                    bp.dst_wr_en, bp.dst_wr_addr}), '0);
    check({tag, " data_per"}, bp.dst_wr_data, '0);
    check({tag, " ctl_wall"}, DWF'({bw.busy, bw.done, bw.step_count, bw.src_rd_en, bw.src_rd_addr,
                                    bw.dst_wr_en, bw.dst_wr_addr}), '0);
    check({tag, " data_wall"}, bw.dst_wr_data, '0);
  endtask

  // Raise start for one sampling edge; returns in the first READ cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count cycles until done is seen, bounded.
  task automatic wait_done(inout int cyc);
    while (!bp.done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [AW-1:0]  hold_addr;
    logic [DWF-1:0] hold_data;

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("idle_busy", DWF'({bp.busy, bw.busy}), '0);
    end
    rst = 1'b1;
    #1;
    check_zero("reset_idle");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Sweep 1: plain timing and streamed values
    pulse_start();
    check("busy_after_start", DWF'({bp.busy, bw.busy, bp.src_rd_en}), DWF'(3'b111));
    cyc = 0;
    wait_done(cyc);
    check("sweep1_cycles", DWF'(cyc), DWF'(176));
    check("sweep1_done_wall", DWF'(bw.done), DWF'(1));
    check("sweep1_step_per", DWF'(bp.step_count), DWF'(1));
    check("sweep1_step_wall", DWF'(bw.step_count), DWF'(1));
    check("per_n0_f1", DWF'(got_word[0][0][1*DW +: DW]), DWF'(49));
    check("per_n0_f4", DWF'(got_word[0][0][4*DW +: DW]), DWF'(68));
    check("per_n0_f5", DWF'(got_word[0][0][5*DW +: DW]), DWF'(245));
    check("per_n0_f0", DWF'(got_word[0][0][0*DW +: DW]), DWF'(0));
    check("wall_n0_f2", DWF'(got_word[1][0][2*DW +: DW]), DWF'(4));
    check("wall_n13_f4", DWF'(got_word[1][13][4*DW +: DW]), DWF'(210));
    check("wall_n5_f2", DWF'(got_word[1][5][2*DW +: DW]), DWF'(18));
    @(posedge clk); #1;
    check("busy_after_done", DWF'({bp.busy, bp.done}), '0);
    @(posedge clk); #1;

    // Sweep 2: 5-cycle backpressure on node 0, plus a start while busy
    pulse_start();
    cyc = 0;
    while (!bp.dst_wr_en && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("first_write_cycle", DWF'(cyc), DWF'(10));
    ready = 1'b0;
    hold_addr = bp.dst_wr_addr;
    hold_data = bp.dst_wr_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cyc++;
      start = (i == 2);
      check("stall_wr_en", DWF'({bp.dst_wr_en, bw.dst_wr_en}), DWF'(2'b11));
      check("stall_addr", DWF'(bp.dst_wr_addr), DWF'(hold_addr));
      check("stall_data", bp.dst_wr_data, hold_data);
      check("stall_no_rd", DWF'({bp.src_rd_en, bw.src_rd_en}), '0);
    end
    ready = 1'b1;
    start = 1'b0;
    wait_done(cyc);
    check("sweep2_cycles", DWF'(cyc), DWF'(181));
    check("sweep2_step", DWF'({bp.step_count, bw.step_count}), DWF'({3'd2, 3'd2}));
`ifdef LBM_STREAM_PERF_EN
    check("stall_cycles_per", DWF'(bp.stall_cycles), DWF'(5));
    check("stall_cycles_wall", DWF'(bw.stall_cycles), DWF'(5));
`endif
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Reset while writing node 7
    pulse_start();
    cyc = 0;
    while (!(bp.dst_wr_en && bp.dst_wr_addr == AW'(7)) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("node7_write_cycle", DWF'(cyc), DWF'(7*11 + 10));
    rst = 1'b1;
    #1;
    check_zero("reset_mid_sweep");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("after_reset_quiet", DWF'({bp.busy, bp.dst_wr_en, bw.dst_wr_en}), '0);
    end

    // Eight back-to-back sweeps with start held high throughout
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (!bp.done && cyc < 3000);
      check($sformatf("b2b_interval_%0d", k), DWF'(cyc), DWF'((k == 1) ? 177 : 178));
      check($sformatf("b2b_step_per_%0d", k), DWF'(bp.step_count), DWF'(k % 8));
      check($sformatf("b2b_step_wall_%0d", k), DWF'(bw.step_count), DWF'(k % 8));
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_restart_after_done", DWF'({bp.busy, bw.busy, bp.src_rd_en}), '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
